alu_exec_stage: RTL
===================

Name: alu_exec_stage

Overview:
- Execute stage directly downstream of the ALU decoder in the RV32I pipeline.
- Latches the decoded ALUop, operands, immediate and destination into a single output register, computes the ALU result, and presents it to writeback over a valid/ready handshake.
- Provides an EX->EX bypass from its own output register, a flush input for branch/jump redirects, and a retired-op counter.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 32, width of retired-op counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage can accept this cycle.
- in_aluop  in  4  ALU operation, `ALU_*` encoding from ALUop.vh.
- in_itype  in  1  1 = operand B is in_imm; 0 = operand B is rs2 data.
- in_rs1_idx  in  5  source register 1 index.
- in_rs2_idx  in  5  source register 2 index.
- in_rs1_data  in  XLEN  regfile read data 1.
- in_rs2_data  in  XLEN  regfile read data 2.
- in_imm  in  XLEN  sign-extended immediate.
- in_rd  in  5  destination index.
- in_we  in  1  instruction writes rd.
- flush  in  1  kill the held instruction.
- out_valid  out  1  result register holds a live instruction.
- out_ready  in  1  writeback consumes this cycle.
- out_result  out  XLEN  registered ALU result.
- out_rd  out  5  registered destination.
- out_we  out  1  registered write enable, gated by out_valid.
- retired_cnt  out  CNT_W  number of completed handshakes.

Behaviour:
- Reset is asynchronous and active-high. On reset: out_valid=0, out_result=0, out_rd=0, out_we=0, retired_cnt=0. Reset asserted mid-transfer drops the held instruction without counting it.
- in_ready = !out_valid || out_ready. This is combinational and does not depend on in_valid.
- Load condition: in_valid && in_ready && !flush. On a load, out_* take the new values on the next rising edge. Latency is 1 cycle.
- If out_ready && out_valid and there is no load: out_valid goes to 0 next cycle. out_result and out_rd hold their values. out_we must read 0 whenever out_valid=0.
- If !out_ready && out_valid: all out_* hold, and in_ready=0.
- flush has priority over everything. It sets out_valid=0 next cycle and blocks the load that cycle. A flush with out_ready=1 in the same cycle still counts the retire if out_valid was 1.
- Bypass operand A: use out_result when out_valid && out_we && out_rd!=0 && out_rd==in_rs1_idx; otherwise use in_rs1_data.
- Bypass operand B: same rule with in_rs2_idx, applied only when in_itype=0. When in_itype=1, B is in_imm.
- ALU operations, all XLEN wide:
  - ADD/SUB: modulo 2^XLEN.
  - SLL/SRL/SRA: shift amount is B[4:0]. SRA is arithmetic.
  - SLT: signed compare, produces 0 or 1.
  - SLTU: unsigned compare, produces 0 or 1.
  - XOR, OR, AND: bitwise.
  - COPY_B: result = B.
  - ALU_XXX and any unlisted code: result = 0.
- retired_cnt increments by 1 on each cycle where out_valid && out_ready, and wraps from 2^CNT_W-1 to 0.
- Simultaneous retire and load: the counter increments and the new instruction loads in the same edge. out_valid stays 1.

Test Plan:
- Reset then ADD: rs1=5, rs2=7, itype=0, rd=3, we=1, in_valid=1, out_ready=1 -> next cycle out_valid=1, out_result=12, out_rd=3, out_we=1; retired_cnt=1 one cycle later.
- Bypass: ADDI x1=x0+0x10 followed back-to-back by ADD rd=2, rs1=x1 (regfile supplies stale 0), rs2=x1 -> second result=0x20. Repeat with rd=0 on the first op -> no bypass, result=0.
- Backpressure: out_ready=0 with out_valid=1 -> in_ready=0 and out_result holds for 5 cycles. Then out_ready=1 -> retired_cnt +1 and the next op loads on the same edge.
- Flush: load SUB 3-5, then assert flush with out_ready=0 -> out_valid=0 next cycle, out_we=0, retired_cnt unchanged. A valid input in the flush cycle is not loaded.
- Shift/compare corners: SRA 0x80000000 by 31 -> 0xFFFFFFFF; SRL same -> 0x00000001; SLT -1<1 -> 1; SLTU 0xFFFFFFFF<1 -> 0; SLL by B=0x21 -> shift by 1.
- Async reset asserted while out_valid=1 mid-clock-period -> out_valid=0 immediately, before the next edge; retired_cnt=0.

Source files
------------

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - RV32I execute stage: operand bypass, ALU and one output register on a valid/ready handshake
// Keeps a retired-instruction counter; flush kills the held instruction.
module alu_exec_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_aluop,
  input  logic             in_itype,
  input  logic [4:0]       in_rs1_idx,
  input  logic [4:0]       in_rs2_idx,
  input  logic [XLEN-1:0]  in_rs1_data,
  input  logic [XLEN-1:0]  in_rs2_data,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [4:0]       in_rd,
  input  logic             in_we,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [4:0]       out_rd,
  output logic             out_we,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_COPY_B = 4'd10;

  logic             valid_q, valid_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [4:0]       rd_q, rd_d;
  logic             we_q, we_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             load;
  logic             retire;
  logic             fwd_ok;
  logic [XLEN-1:0]  op_a;
  logic [XLEN-1:0]  op_b;
  logic [4:0]       shamt;
  logic [XLEN-1:0]  alu_res;

  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready && !flush;
  assign retire   = valid_q && out_ready;

  // Only the instruction sitting in our own output register can be forwarded.
  assign fwd_ok = valid_q && we_q && (rd_q != 5'd0);
  assign op_a   = (fwd_ok && rd_q == in_rs1_idx) ? result_q : in_rs1_data;
  assign op_b   = in_itype ? in_imm :
                  ((fwd_ok && rd_q == in_rs2_idx) ? result_q : in_rs2_data);
  assign shamt  = op_b[4:0];

  always_comb begin
    alu_res = '0;
    case (in_aluop)
      ALU_ADD:    alu_res = op_a + op_b;
      ALU_SUB:    alu_res = op_a - op_b;
      ALU_SLL:    alu_res = op_a << shamt;
      ALU_SLT:    alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:   alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      ALU_XOR:    alu_res = op_a ^ op_b;
      ALU_SRL:    alu_res = op_a >> shamt;
      ALU_SRA:    alu_res = $signed(op_a) >>> shamt;
      ALU_OR:     alu_res = op_a | op_b;
      ALU_AND:    alu_res = op_a & op_b;
      ALU_COPY_B: alu_res = op_b;
      default:    alu_res = '0;
    endcase
  end

  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    rd_d     = rd_q;
    we_d     = we_q;
    cnt_d    = cnt_q + CNT_W'(retire);
    if (retire) begin
      valid_d = 1'b0;
    end
    if (load) begin
      valid_d  = 1'b1;
      result_d = alu_res;
      rd_d     = in_rd;
      we_d     = in_we;
    end
    // Flush wins, but a retire in the same cycle was already consumed and still counts.
    if (flush) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
      we_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_result  = result_q;
  assign out_rd      = rd_q;
  assign out_we      = we_q && valid_q;
  assign retired_cnt = cnt_q;

endmodule
